// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared definitions for the PWM input-capture block.
// Holds the capture FSM state encoding, the register address map
// (decoded from wb_adr[1:0]) and the CTRL register bit positions.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_HIGH   = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_DONE   = 3;
  localparam int CTRL_OVF    = 4;
  localparam int CTRL_LEVEL  = 5;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: 16-bit Wishbone slave bus of the capture block.
//
// Handshake: a request is cyc & stb while ack is low. The slave raises
// o_wb_ack for exactly one clock on the cycle after the request and
// registers o_wb_data alongside it; a write lands on that same edge. The
// master keeps cyc/stb/we/adr/data stable until it sees ack and must drop
// stb (or start a new access) afterwards, so back-to-back strobes are
// acknowledged every other cycle.
//
// Signals: i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr[15:0], i_wb_data[15:0]
// (master -> slave); o_wb_ack, o_wb_data[15:0] (slave -> master).
interface pwm_capture_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [15:0] i_wb_adr;
  logic [15:0] i_wb_data;
  logic        o_wb_ack;
  logic [15:0] o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
    output o_wb_ack, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_data,
    input  o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: brings the asynchronous PWM input into the clock
// domain and produces single-cycle edge pulses.
// Optional glitch filter enabled by the macro PWM_CAPTURE_FILT_EN: a new
// level must persist for 3 consecutive clocks before it is accepted.
//
// Ports: clk, rst (async, active-high), pwm (async input);
//        level (accepted level), rise / fall (one pulse per transition).
module pwm_capture_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_int;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
    end
  end

`ifdef PWM_CAPTURE_FILT_EN
  logic       filt_q;
  logic [1:0] run_q;

  // run_q counts consecutive clocks the synchronized input has disagreed
  // with the accepted level; the third such clock commits the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= 2'd0;
    end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (run_q == 2'd2) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        run_q  <= 2'd0;
      end else begin
        run_q <= run_q + 2'd1;
      end
    end else begin
      run_q <= 2'd0;
    end
  end

  assign level_int = filt_q;
`else
  assign level_int = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_int;
    end
  end

  assign level = level_int;
  assign rise  = level_int & ~prev_q;
  assign fall  = ~level_int & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM signal.
// Optional input glitch filter: define PWM_CAPTURE_FILT_EN.
//
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   wb            Wishbone slave (pwm_capture_if.slave)
//                 0 CTRL: EN, CONT, IRQ_EN, DONE(W1C), OVF(W1C), LEVEL(ro)
//                 1 DIV, 2 PERIOD (ro), 3 HIGH (ro)
//   i_pwm         asynchronous PWM input
//   o_irq         level interrupt, IRQ_EN & (DONE | OVF), registered
//   o_state       current capture FSM state (debug)
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pwm_capture_if.slave         wb,
  input  logic                 i_pwm,
  output logic                 o_irq,
  output state_t               o_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             level, rise, fall;
  state_t           state;
  logic             en, cont, irq_en, done, ovf;
  logic [15:0]      div_r;
  logic [15:0]      psc;
  logic [15:0]      div_eff;
  logic             tick;
  logic [CNT_W-1:0] cnt, cnt_cap;
  logic [CNT_W-1:0] high_shadow, period_r, high_r;
  logic             wb_req, wr_ctrl, wr_div;
  logic             done_set, ovf_set;
  logic [15:0]      rd_data;
  logic             unused_adr;

  assign unused_adr = ^wb.i_wb_adr[15:2];

  pwm_capture_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (i_clk),
    .rst   (i_rst),
    .pwm   (i_pwm),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // psc counts clocks since the last rising edge (1..div_eff), so ticks
  // fall on distances d, 2d, ... from the edge and a result read as
  // cnt + tick on the closing edge equals floor(distance / d).
  assign div_eff = (div_r == 16'd0) ? 16'd1 : div_r;
  assign tick    = (psc >= div_eff);
  assign cnt_cap = (tick && cnt != CNT_MAX) ? cnt + CNT_ONE : cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      psc <= 16'd0;
    end else if (rise || tick) begin
      psc <= 16'd1;
    end else begin
      psc <= psc + 16'd1;
    end
  end

  always_comb begin
    wb_req   = wb.i_wb_cyc & wb.i_wb_stb & ~wb.o_wb_ack;
    wr_ctrl  = wb_req & wb.i_wb_we & (wb.i_wb_adr[1:0] == ADDR_CTRL);
    wr_div   = wb_req & wb.i_wb_we & (wb.i_wb_adr[1:0] == ADDR_DIV);
    done_set = en && (state == ST_LO) && rise;
    ovf_set  = en && (cnt == CNT_MAX) &&
               (((state == ST_HI) && !fall) || ((state == ST_LO) && !rise));
  end

  always_comb begin
    rd_data = '0;
    case (wb.i_wb_adr[1:0])
      ADDR_CTRL: begin
        rd_data[CTRL_EN]     = en;
        rd_data[CTRL_CONT]   = cont;
        rd_data[CTRL_IRQ_EN] = irq_en;
        rd_data[CTRL_DONE]   = done;
        rd_data[CTRL_OVF]    = ovf;
        rd_data[CTRL_LEVEL]  = level;
      end
      ADDR_DIV:    rd_data = div_r;
      ADDR_PERIOD: rd_data[CNT_W-1:0] = period_r;
      default:     rd_data[CNT_W-1:0] = high_r;
    endcase
  end

  // Capture FSM plus the registers it shares with the bus. HIGH is held in
  // high_shadow until the period closes so PERIOD/HIGH always update as a pair.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      en          <= 1'b0;
      cont        <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      div_r       <= 16'd0;
      cnt         <= '0;
      high_shadow <= '0;
      period_r    <= '0;
      high_r      <= '0;
    end else begin
      if (!en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM:  if (rise) state <= ST_HI;
          ST_HI: begin
            if (fall) begin
              high_shadow <= cnt_cap;
              state       <= ST_LO;
            end else if (cnt == CNT_MAX) begin
              state <= ST_ARM;
            end
          end
          ST_LO: begin
            if (rise) begin
              period_r <= cnt_cap;
              high_r   <= high_shadow;
              state    <= cont ? ST_HI : ST_IDLE;
            end else if (cnt == CNT_MAX) begin
              state <= ST_ARM;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (rise) begin
        cnt <= '0;
      end else if ((state == ST_HI || state == ST_LO) && tick && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end

      // A software write of EN takes priority over the single-shot auto-clear.
      if (wr_ctrl) begin
        en     <= wb.i_wb_data[CTRL_EN];
        cont   <= wb.i_wb_data[CTRL_CONT];
        irq_en <= wb.i_wb_data[CTRL_IRQ_EN];
      end else if (done_set && !cont) begin
        en <= 1'b0;
      end

      // Hardware set beats a simultaneous write-1-to-clear.
      done <= (done & ~(wr_ctrl & wb.i_wb_data[CTRL_DONE])) | done_set;
      ovf  <= (ovf  & ~(wr_ctrl & wb.i_wb_data[CTRL_OVF]))  | ovf_set;

      if (wr_div) begin
        div_r <= wb.i_wb_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= 16'd0;
    end else begin
      wb.o_wb_ack  <= wb_req;
      wb.o_wb_data <= (wb_req && !wb.i_wb_we) ? rd_data : 16'd0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= irq_en & (done | ovf);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture.
// Inputs change 1 time unit after the rising clock edge; outputs are
// sampled at the same point, away from the active edge.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  logic   clk;
  logic   rst;
  logic   pwm;
  logic   irq;
  state_t dbg_state;
  int     n_checks;
  int     n_pass;
  int     waited;
  logic [15:0] rd;

  pwm_capture_if bus ();

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .wb      (bus),
    .i_pwm   (pwm),
    .o_irq   (irq),
    .o_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wb_xfer(input logic we, input logic [15:0] adr,
                         input logic [15:0] wdat, output logic [15:0] rdat);
    bit got;
    got  = 1'b0;
    rdat = 16'd0;
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_adr  = adr;
    bus.i_wb_data = wdat;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.o_wb_ack) begin
        got  = 1'b1;
        rdat = bus.o_wb_data;
        break;
      end
    end
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [15:0] adr, input logic [15:0] d);
    logic [15:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_read(input logic [15:0] adr, output logic [15:0] d);
    wb_xfer(1'b0, adr, 16'd0, d);
  endtask

  task automatic drive_pwm(input logic v, input int n);
    pwm = v;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    pwm = 1'b0;
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_adr  = 16'd0;
    bus.i_wb_data = 16'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, bus.o_wb_ack}, 32'd0);
    check("rst_rdata", {16'd0, bus.o_wb_data}, 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(16'd0, rd);  check("rst_ctrl", {16'd0, rd}, 32'h0);
    wb_read(16'd2, rd);  check("rst_period", {16'd0, rd}, 32'h0);

    // 1: DIV=1, continuous, 30 high / 70 low
    wb_write(16'd1, 16'd1);
    wb_write(16'd0, 16'h0007);
    drive_pwm(1'b1, 30);
    drive_pwm(1'b0, 70);
    drive_pwm(1'b1, 12);
    check("t1_irq", {31'd0, irq}, 32'd1);
    wb_read(16'd2, rd);  check("t1_period", {16'd0, rd}, 32'd100);
    wb_read(16'd3, rd);  check("t1_high", {16'd0, rd}, 32'd30);
    wb_read(16'd0, rd);  check("t1_ctrl", {16'd0, rd}, 32'h2F);

    // 2: DIV=4 (upper address bits alias), then W1C DONE
    wb_write(16'h0105, 16'd4);
    drive_pwm(1'b0, 70);
    drive_pwm(1'b1, 30);
    drive_pwm(1'b0, 70);
    drive_pwm(1'b1, 12);
    wb_read(16'd2, rd);  check("t2_period", {16'd0, rd}, 32'd25);
    wb_read(16'd3, rd);  check("t2_high", {16'd0, rd}, 32'd7);
    wb_write(16'd0, 16'h000F);
    wb_read(16'd0, rd);  check("t2_ctrl_w1c", {16'd0, rd}, 32'h27);
    check("t2_irq_clr", {31'd0, irq}, 32'd0);

    // 3: single-shot, DIV=0 behaves as 1, period 50 then a period of 80
    wb_write(16'd0, 16'h0000);
    wb_write(16'd1, 16'd0);
    drive_pwm(1'b0, 20);
    wb_write(16'd0, 16'h0005);
    drive_pwm(1'b1, 20);
    drive_pwm(1'b0, 30);
    drive_pwm(1'b1, 40);
    drive_pwm(1'b0, 40);
    drive_pwm(1'b1, 12);
    wb_read(16'd2, rd);  check("t3_period", {16'd0, rd}, 32'd50);
    wb_read(16'd3, rd);  check("t3_high", {16'd0, rd}, 32'd20);
    wb_read(16'd0, rd);  check("t3_ctrl", {16'd0, rd}, 32'h2C);
    check("t3_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("t3_irq", {31'd0, irq}, 32'd1);

    // 5: clear EN mid-measurement, re-enable, full period follows
    wb_write(16'd0, 16'h000F);
    drive_pwm(1'b0, 20);
    drive_pwm(1'b1, 25);
    drive_pwm(1'b0, 15);
    wb_write(16'd0, 16'h0006);
    wb_read(16'd2, rd);  check("t5_period_hold", {16'd0, rd}, 32'd50);
    drive_pwm(1'b0, 10);
    wb_write(16'd0, 16'h0007);
    drive_pwm(1'b0, 5);
    drive_pwm(1'b1, 15);
    drive_pwm(1'b0, 45);
    drive_pwm(1'b1, 12);
    wb_read(16'd2, rd);  check("t5_period", {16'd0, rd}, 32'd60);
    wb_read(16'd3, rd);  check("t5_high", {16'd0, rd}, 32'd15);
    wb_read(16'd0, rd);  check("t5_ctrl", {16'd0, rd}, 32'h2F);

    // 4: input stuck high -> counter saturates -> OVF
    wb_write(16'd0, 16'h000F);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("t4_irq_pre", {31'd0, irq}, 32'd0);
    waited = 0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      waited++;
      if (irq) break;
    end
    check("t4_irq", {31'd0, irq}, 32'd1);
    check("t4_ovf_time", {31'd0, (waited > 65400 && waited < 65560)}, 32'd1);
    check("t4_state", {30'd0, dbg_state}, {30'd0, ST_ARM});
    wb_read(16'd0, rd);  check("t4_ctrl", {16'd0, rd}, 32'h37);
    wb_read(16'd2, rd);  check("t4_period", {16'd0, rd}, 32'd60);
    wb_read(16'd3, rd);  check("t4_high", {16'd0, rd}, 32'd15);

    // 6: asynchronous reset in the middle of a measurement
    drive_pwm(1'b0, 10);
    drive_pwm(1'b1, 10);
    #2;
    rst = 1'b1;
    #1;
    check("t6_irq_async", {31'd0, irq}, 32'd0);
    check("t6_ack_async", {31'd0, bus.o_wb_ack}, 32'd0);
    check("t6_rdata_async", {16'd0, bus.o_wb_data}, 32'd0);
    check("t6_state_async", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    pwm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(16'd0, rd);  check("t6_ctrl", {16'd0, rd}, 32'h0);
    wb_read(16'd1, rd);  check("t6_div", {16'd0, rd}, 32'h0);
    wb_read(16'd2, rd);  check("t6_period", {16'd0, rd}, 32'h0);
    wb_read(16'd3, rd);  check("t6_high", {16'd0, rd}, 32'h0);

    // 2-clock glitch: filtered build stays armed, unfiltered one sees it
    wb_write(16'd1, 16'd1);
    wb_write(16'd0, 16'h0007);
    drive_pwm(1'b0, 5);
    drive_pwm(1'b1, 2);
    drive_pwm(1'b0, 20);
`ifdef PWM_CAPTURE_FILT_EN
    check("glitch_state", {30'd0, dbg_state}, {30'd0, ST_ARM});
`else
    check("glitch_state", {30'd0, dbg_state}, {30'd0, ST_LO});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
